cla_serial_add16: RTL and testbench
===================================

CLA_SERIAL_ADD16 -- requirements
Module: cla_serial_add16

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES and NIBBLES >= 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 The block SHALL have port a, input, W bits: addend A.
REQ-007 The block SHALL have port b, input, W bits: addend B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port sum, output, W bits: a+b+cin modulo 2^W.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of bit W-1.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement overflow, i.e. carry into bit W-1 XOR cout.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; it SHALL NOT be asserted in DONE, even when out_ready is 1.
REQ-017 IDLE -> RUN SHALL occur on an accept edge (in_valid && in_ready); on that edge the block SHALL latch a, b and cin into the carry register, clear the nibble index to 0 and clear sum, cout and ovf.
REQ-018 In each RUN cycle, one 4-bit adder slice SHALL add nibble[idx] of the latched A and B plus the carry register.
REQ-019 On that RUN edge, the slice sum SHALL be written to sum[4*idx+3:4*idx], the slice carry-out SHALL be written to the carry register, and idx SHALL increment.
REQ-020 RUN -> DONE SHALL occur on the edge that processes idx = NIBBLES-1; on that edge cout SHALL take the slice carry-out and ovf SHALL be (A[W-1]^B[W-1]^sum_msb) ^ carry-out.
REQ-021 Latency: out_valid SHALL rise exactly NIBBLES+1 rising edges after the accept edge, counting the accept edge itself (5 edges at the default).
REQ-022 DONE -> IDLE SHALL occur on an edge with out_ready=1; while out_ready=0, the block SHALL hold sum, cout, ovf and out_valid stable indefinitely.
REQ-023 Minimum issue interval SHALL be NIBBLES+2 cycles.
REQ-024 Changes on a, b, cin and in_valid outside the accept edge SHALL have no effect on the operation in flight.
REQ-025 sum, cout and ovf SHALL keep their last values in IDLE until the next accept edge.
REQ-026 NIBBLES=1 SHALL be legal: RUN lasts one cycle and latency is 2 edges.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL go to IDLE, clear idx and the carry register, and set sum=0, cout=0, ovf=0 and out_valid=0; in_ready SHALL be 1 after reset.
REQ-028 A reset during RUN or DONE SHALL discard the operation in flight without producing any out_valid pulse; the first edge with rst_n=1 SHALL be able to accept new operands.

Structure
REQ-029 Shared package cla_pkg SHALL hold NIBBLE_W=4 and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2); 2'd3 SHALL map to IDLE.
REQ-030 The block SHALL contain exactly one instance of the team's existing 4-bit carry-lookahead adder carry_top (a, b, cin -> sum, cout) as the slice, fed from the latched operands by an idx-selected mux; the block SHALL contain no other adder.

Verification
REQ-031 a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0, ovf=0; out_valid rises on the 5th edge after accept.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, with the carry rippling across all 4 nibbles.
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0x1234, b=0x5678, cin=1 -> sum=0x68AD, cout=0, ovf=0.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> outputs are stable and in_ready=0; raise out_ready -> IDLE on the next edge; next op a=0x0101, b=0x0202, cin=0 -> sum=0x0303.
REQ-035 Assert rst_n=0 for one edge after 2 RUN cycles -> no out_valid pulse and all outputs 0; then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
REQ-036 Change a and b every cycle during RUN -> the result matches the operands latched at the accept edge.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and FSM encoding for the nibble-serial CLA adder.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_top.sv
// 4-bit carry-lookahead adder slice: all carries from generate/propagate terms.
import cla_pkg::*;

module carry_top (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g, p;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[NIBBLE_W-1:0];
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/cla_serial_add16.sv
// Nibble-serial adder: one shared CLA slice walks the latched operands LSB-first,
// rippling the carry through a register, then holds the result until taken.
import cla_pkg::*;

module cla_serial_add16 #(
  parameter int NIBBLES = 4,
  localparam int W      = NIBBLE_W * NIBBLES,
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  state_e                              state_q, state_d, state_eff;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic                                carry_q, carry_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                                cout_q, cout_d, ovf_q, ovf_d;
  logic [NIBBLE_W-1:0]                 slice_a, slice_b, slice_sum;
  logic                                slice_cout;
  logic                                last_nib;

  // The unused encoding 2'd3 decodes as IDLE everywhere.
  assign state_eff = (state_q == RUN || state_q == DONE) ? state_q : IDLE;

  assign slice_a  = a_q[idx_q];
  assign slice_b  = b_q[idx_q];
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  carry_top u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_eff)
      RUN: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (last_nib) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = slice_cout;
          // carry into the MSB recovered from the MSB sum bit
          ovf_d   = a_q[NIBBLES-1][NIBBLE_W-1] ^ b_q[NIBBLES-1][NIBBLE_W-1]
                  ^ slice_sum[NIBBLE_W-1] ^ slice_cout;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_eff == IDLE);
  assign out_valid = (state_eff == DONE);
  assign busy      = (state_eff != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_add16.sv
// Random and directed operand sets against an arithmetic reference model.
module tb_cla_serial_add16;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  int n_run = 0;
  int n_fail = 0;

  cla_serial_add16 #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  task automatic ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endtask

  // Issue one operation, scramble inputs during RUN, check latency, result and hold.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input int hold);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;
    ref_add(x, y, ci, es, ec, eo);
    @(negedge clk);
    chk("in_ready_before", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = x; b = y; cin = ci; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("latency", lat, N + 1);
    chk("sum", {16'd0, sum}, {16'd0, es});
    chk("cout", {31'd0, cout}, {31'd0, ec});
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_res", {15'd0, sum, cout, ovf}, {15'd0, es, ec, eo});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ready", {30'd0, in_ready, busy}, 32'd2);
    chk("idle_keep", {15'd0, sum, cout, ovf}, {15'd0, es, ec, eo});
  endtask

  initial begin
    bit saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {13'd0, sum, cout, ovf, out_valid}, 32'd0);
    chk("rst_ready", {30'd0, in_ready, busy}, 32'd2);
    rst_n = 1'b1;

    run_op(16'h0000, 16'h0000, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1);
    run_op(16'h1234, 16'h5678, 1'b1, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 3);
    run_op(16'h0101, 16'h0202, 1'b0, 0);

    // Reset after two RUN edges must abort silently.
    @(negedge clk);
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    saw_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (out_valid) saw_valid = 1'b1;
    chk("rst_no_pulse", {31'd0, saw_valid}, 32'd0);
    chk("rst_mid_out", {13'd0, sum, cout, ovf, out_valid}, 32'd0);
    chk("rst_mid_ready", {30'd0, in_ready, busy}, 32'd2);
    rst_n = 1'b1;
    run_op(16'h8000, 16'h8000, 1'b0, 0);

    for (int i = 0; i < 25; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
